stack_ptr_ctrl: RTL

LIFO stack controller for the register-file memory: owns the write pointer, occupancy and wrap detection, and drives one-hot word lines and a top-of-stack read port into the memory array. It sits directly upstream of the memory read/mux stage that consumes `word_line`, `ptr` and `wrapout`. It also provides a multi-cycle scrub that zeroes every entry.

---
 rtl/stack_pkg.sv | 21 ++
 rtl/stack_ptr_ctrl_if.sv | 35 +++
 rtl/stack_mem.sv | 24 ++
 rtl/stack_ptr_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared types, default sizes and the one-hot decode helper for the stack controller.
package stack_pkg;

  localparam int unsigned DEFAULT_DEPTH = 8;
  localparam int unsigned DEFAULT_WIDTH = 24;
  localparam int unsigned ONEHOT_MAX    = 256;

  typedef enum logic {
    ST_IDLE,
    ST_SCRUB
  } state_e;

  // Wide one-hot decode; callers truncate to their own depth (depth must not exceed ONEHOT_MAX).
  function automatic logic [ONEHOT_MAX-1:0] onehot_f(input logic [7:0] idx);
    logic [ONEHOT_MAX-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/stack_ptr_ctrl_if.sv
// Push/pop handshake, scrub control and memory-side pointer signals of stack_ptr_ctrl.
interface stack_ptr_ctrl_if
  import stack_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic             push_valid;
  logic             push_ready;
  logic [WIDTH-1:0] push_data;
  logic             pop_valid;
  logic             pop_ready;
  logic [WIDTH-1:0] pop_data;
  logic             clear;
  logic             scrub_busy;
  logic [DEPTH-1:0] word_line;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             wrapout;

  modport master (
    output push_valid, push_data, pop_ready, clear,
    input  push_ready, pop_valid, pop_data, scrub_busy, word_line, ptr, count, full, empty, wrapout
  );

  modport slave (
    input  push_valid, push_data, pop_ready, clear,
    output push_ready, pop_valid, pop_data, scrub_busy, word_line, ptr, count, full, empty, wrapout
  );

endinterface

// File: rtl/stack_mem.sv
// DEPTH x WIDTH flop array: one-hot write port, combinational read port, no reset.
module stack_mem #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 24,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [DEPTH-1:0] we,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (we[i]) mem_q[i] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/stack_ptr_ctrl.sv
// LIFO pointer/occupancy controller with multi-cycle scrub.
// Define STACK_PTR_WRAP_EN to accept pushes while full (oldest entry overwritten).
module stack_ptr_ctrl
  import stack_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  stack_ptr_ctrl_if.slave   bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             wrap_q, wrap_d;

  logic             push_ready_c;
  logic             pop_valid_c;
  logic             push_fire;
  logic             pop_fire;
  logic [PTR_W-1:0] top_addr;
  logic [DEPTH-1:0] we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;

`ifdef STACK_PTR_WRAP_EN
  assign push_ready_c = (state_q == ST_IDLE);
`else
  assign push_ready_c = (state_q == ST_IDLE) && !full_q;
`endif
  assign pop_valid_c = (state_q == ST_IDLE) && !empty_q;
  assign push_fire   = bus.push_valid && push_ready_c;
  assign pop_fire    = pop_valid_c && bus.pop_ready;
  assign top_addr    = ptr_q - PTR_W'(1);

  // Next-state, pointer/count update and memory write select.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    we      = '0;
    wdata   = bus.push_data;
    case (state_q)
      ST_IDLE: begin
        if (bus.clear) begin
          ptr_d   = '0;
          count_d = '0;
          idx_d   = '0;
          state_d = ST_SCRUB;
        end else if (push_fire && pop_fire) begin
          we = DEPTH'(onehot_f(8'(top_addr)));
        end else if (push_fire) begin
          we     = DEPTH'(onehot_f(8'(ptr_q)));
          ptr_d  = ptr_q + PTR_W'(1);
          wrap_d = (ptr_q == PTR_W'(DEPTH - 1));
          if (count_q != CNT_W'(DEPTH)) count_d = count_q + CNT_W'(1);
        end else if (pop_fire) begin
          ptr_d   = ptr_q - PTR_W'(1);
          count_d = count_q - CNT_W'(1);
        end
      end
      ST_SCRUB: begin
        we    = DEPTH'(onehot_f(8'(idx_q)));
        wdata = '0;
        idx_d = idx_q + PTR_W'(1);
        if (bus.clear) begin
          idx_d = '0;
        end else if (idx_q == PTR_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      wrap_q  <= wrap_d;
    end
  end

  stack_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .wdata (wdata),
    .raddr (top_addr),
    .rdata (rdata)
  );

  assign bus.push_ready = push_ready_c;
  assign bus.pop_valid  = pop_valid_c;
  assign bus.pop_data   = pop_valid_c ? rdata : '0;
  assign bus.scrub_busy = (state_q == ST_SCRUB);
  assign bus.word_line  = we;
  assign bus.ptr        = ptr_q;
  assign bus.count      = count_q;
  assign bus.full       = full_q;
  assign bus.empty      = empty_q;
  assign bus.wrapout    = wrap_q;

endmodule
